mesh_terminal_port: RTL and testbench
=====================================

Name: mesh_terminal_port

Overview:
- Terminal-side endpoint that attaches one terminal to one mesh_gnrtr interface.
- TX path: accepts user packets, formats them, buffers them in a FIFO and presents them to the mesh. The mesh reads them through data_out_i_in/pndng_i_in and consumes them with popin.
- RX path: drains packets the mesh delivers on data_out/pndng by pulsing pop, then checks each packet's destination against this terminal's own position.
- This block is the terminal (producer/consumer) end of the mesh handshake that the agent/driver/monitor currently model in the testbench.

Parameters:
- pckg_sz, 40, packet width in bits (≥ 24).
- fifo_depth, 16, TX FIFO entries (power of 2, ≥ 2).
- MY_ROW, 1, this terminal's row (4 bits).
- MY_COL, 1, this terminal's column (4 bits).
- broadcast, 8'hFF, nxt_jmp value marking a broadcast packet.

Ports:
- clk in 1: clock, all logic on posedge.
- reset in 1: synchronous, active-low.
- tx_valid in 1: user offers a packet.
- tx_ready out 1: TX FIFO can accept.
- tx_bcast in 1: send as broadcast.
- tx_row in 4: destination row.
- tx_col in 4: destination column.
- tx_mode in 1: routing mode bit.
- tx_payload in pckg_sz-17: payload.
- data_out_i_in out pckg_sz: TX FIFO head toward the mesh.
- pndng_i_in out 1: TX FIFO non-empty.
- popin in 1: mesh consumed the head.
- data_out in pckg_sz: packet from the mesh.
- pndng in 1: mesh has a packet for this terminal.
- pop out 1: one-cycle consume pulse to the mesh.
- rx_valid out 1: rx_data is held.
- rx_ready in 1: user takes rx_data.
- rx_data out pckg_sz: captured packet.
- rx_misroute out 1: captured packet's row/col does not match MY_ROW/MY_COL and it is not a broadcast.
- tx_cnt out 16: packets popped by the mesh.
- rx_cnt out 16: packets received.
- err_cnt out 16: misroutes plus popin-while-empty events.

Behaviour:
- Packet format, MSB first:
  - [pckg_sz-1 -: 8] nxt_jmp = broadcast if tx_bcast, else 8'h00.
  - [pckg_sz-9 -: 4] row.
  - [pckg_sz-13 -: 4] col.
  - [pckg_sz-17] mode.
  - [pckg_sz-18:0] payload.
- Reset (reset==0 at posedge):
  - FIFO emptied.
  - tx_ready=1, pndng_i_in=0, data_out_i_in=0.
  - pop=0, rx_valid=0, rx_data=0, rx_misroute=0.
  - All counters 0.
  - RX FSM → IDLE.
  - Reset mid-transfer discards all buffered and held packets.
- TX FIFO:
  - tx_ready = !full.
  - Push when tx_valid && tx_ready; the entry is written at the posedge.
  - pndng_i_in = !empty.
  - data_out_i_in = head entry, combinational from storage; 0 when empty.
  - popin && !empty: advance head, tx_cnt += 1.
  - popin && empty: ignored, err_cnt += 1.
  - Push and pop in the same cycle (not full): both occur, occupancy unchanged.
  - When full: push blocked. A simultaneous pop does not open tx_ready in that cycle; tx_ready returns the next cycle.
  - Pointers wrap modulo fifo_depth. Occupancy counter is log2(fifo_depth)+1 bits.
  - Latency: packet pushed at edge N gives pndng_i_in=1 after edge N when the FIFO was empty.
- RX FSM, states IDLE, POP, GAP, HOLD:
  - IDLE: if pndng, go to POP.
  - POP: pop=1 for exactly this cycle. Capture data_out into rx_data, compute rx_misroute, rx_cnt += 1, err_cnt += misroute. Go to GAP.
  - GAP: pop=0; one-cycle guard so the mesh's pndng can update. Go to HOLD with rx_valid=1.
  - HOLD: rx_valid=1 until rx_ready is seen at a posedge, then rx_valid=0 and go to IDLE.
  - No pop is ever issued while rx_valid=1.
  - Minimum RX period is 4 cycles per packet.
- Broadcast packets (nxt_jmp==broadcast) never flag misroute.
- Counters saturate at 16'hFFFF, no wrap.
- tx_cnt and err_cnt increments in the same cycle are independent; err_cnt adds misroute and underflow, each at most once per cycle, saturating.

Test Plan:
- Reset then idle 5 cycles → tx_ready=1, pndng_i_in=0, pop=0, rx_valid=0, all counters 0.
- Push row=2, col=3, mode=1, payload=23'h1ABCDE with tx_bcast=0 → data_out_i_in = {8'h00, 4'h2, 4'h3, 1'b1, 23'h1ABCDE}, pndng_i_in=1 next cycle. popin for 1 cycle → pndng_i_in=0, tx_cnt=1.
- Push 16 packets with no popin → tx_ready=0 after the 16th; a 17th tx_valid is not stored. Then 16 popin pulses → the packets emerge in push order, tx_cnt=16. Repeat across the pointer wrap, order preserved.
- Mesh holds pndng=1 with data_out row=1, col=1, rx_ready=0 → exactly one pop pulse, rx_valid=1, rx_misroute=0, no second pop for 20 cycles. rx_ready=1 → rx_valid drops and a second pop follows.
- Deliver row=3, col=0, nxt_jmp=00 → rx_misroute=1, err_cnt=1. Deliver the same packet with nxt_jmp=FF → rx_misroute=0, err_cnt stays 1.
- popin with the FIFO empty → err_cnt=1, pointers unchanged. Assert reset=0 while in HOLD with 3 entries queued → next cycle everything cleared and pndng_i_in=0.

Source files
------------

// File: rtl/mesh_terminal_port.sv
// mesh_terminal_port
// ------------------
// Terminal-side endpoint for one mesh_gnrtr interface.
//
// TX path: user packets (tx_valid/tx_ready) are formatted into the mesh
// packet layout and buffered in a FIFO. The head of the FIFO is presented to
// the mesh on data_out_i_in with pndng_i_in flagging non-empty; the mesh
// consumes the head by pulsing popin.
//
// RX path: when the mesh raises pndng, a four-state FSM issues a single pop
// pulse, captures data_out, checks the destination against MY_ROW/MY_COL,
// waits one guard cycle so the mesh can update pndng, then holds the packet
// on rx_data/rx_valid until the user accepts it with rx_ready.
//
// Handshakes: a transfer happens on a rising clk edge where the offering
// side's valid and the receiving side's ready are both high. tx_valid may be
// held across cycles; rx_valid stays high until rx_ready is seen at an edge.
//
// Packet layout (MSB first):
//   [pckg_sz-1 -: 8]  nxt_jmp (broadcast value or 8'h00)
//   [pckg_sz-9 -: 4]  row
//   [pckg_sz-13 -: 4] col
//   [pckg_sz-17]      mode
//   [pckg_sz-18:0]    payload
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   tx_valid/tx_ready                user TX handshake
//   tx_bcast/tx_row/tx_col/tx_mode/tx_payload   TX packet fields
//   data_out_i_in/pndng_i_in/popin   TX FIFO head toward the mesh
//   data_out/pndng/pop               packet from the mesh and consume pulse
//   rx_valid/rx_ready/rx_data        user RX handshake and captured packet
//   rx_misroute                      captured packet not addressed here
//   tx_cnt/rx_cnt/err_cnt            saturating 16-bit statistics
module mesh_terminal_port #(
    parameter int unsigned pckg_sz    = 40,
    parameter int unsigned fifo_depth = 16,
    parameter logic [3:0]  MY_ROW     = 4'd1,
    parameter logic [3:0]  MY_COL     = 4'd1,
    parameter logic [7:0]  broadcast  = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    // user TX side
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic               tx_bcast,
    input  logic [3:0]         tx_row,
    input  logic [3:0]         tx_col,
    input  logic               tx_mode,
    input  logic [pckg_sz-18:0] tx_payload,
    // mesh side of the TX FIFO
    output logic [pckg_sz-1:0] data_out_i_in,
    output logic               pndng_i_in,
    input  logic               popin,
    // mesh delivery toward this terminal
    input  logic [pckg_sz-1:0] data_out,
    input  logic               pndng,
    output logic               pop,
    // user RX side
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_misroute,
    // statistics
    output logic [15:0]        tx_cnt,
    output logic [15:0]        rx_cnt,
    output logic [15:0]        err_cnt
);

    localparam int unsigned AW = $clog2(fifo_depth);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(fifo_depth);

    // Saturating add used by all three statistics counters.
    function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        occ_q;

    logic               fifo_full, fifo_empty;
    logic               tx_push, tx_pop, tx_underflow;
    logic [pckg_sz-1:0] tx_pkt;

    assign fifo_full    = (occ_q == DEPTH_C);
    assign fifo_empty   = (occ_q == '0);
    // Push is gated by full only, so a pop in the full cycle cannot admit
    // a push until the following cycle.
    assign tx_push      = tx_valid && !fifo_full;
    assign tx_pop       = popin && !fifo_empty;
    assign tx_underflow = popin && fifo_empty;

    assign tx_pkt = {(tx_bcast ? broadcast : 8'h00), tx_row, tx_col, tx_mode, tx_payload};

    assign tx_ready      = !fifo_full;
    assign pndng_i_in    = !fifo_empty;
    assign data_out_i_in = fifo_empty ? '0 : mem_q[rd_ptr_q];

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            mem_q[wr_ptr_q] <= tx_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (tx_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_POP  = 2'd1,
        RX_GAP  = 2'd2,
        RX_HOLD = 2'd3
    } rx_state_e;

    rx_state_e rx_state_q, rx_state_d;
    logic      rx_capture;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        pop        = 1'b0;
        rx_valid   = 1'b0;
        rx_capture = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (pndng) rx_state_d = RX_POP;
            end
            RX_POP: begin
                pop        = 1'b1;
                rx_capture = 1'b1;
                rx_state_d = RX_GAP;
            end
            // Guard cycle: the mesh sees pop at the end of RX_POP and needs
            // one cycle before its pndng reflects the next packet.
            RX_GAP: begin
                rx_state_d = RX_HOLD;
            end
            RX_HOLD: begin
                rx_valid = 1'b1;
                if (rx_ready) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Destination check of the packet currently offered by the mesh.
    logic [7:0] in_jmp;
    logic [3:0] in_row, in_col;
    logic       in_misroute;

    assign in_jmp      = data_out[pckg_sz-1 -: 8];
    assign in_row      = data_out[pckg_sz-9 -: 4];
    assign in_col      = data_out[pckg_sz-13 -: 4];
    assign in_misroute = (in_jmp != broadcast) && ((in_row != MY_ROW) || (in_col != MY_COL));

    // ------------------------------------------------------------------
    // Captured packet and statistics
    // ------------------------------------------------------------------
    logic [pckg_sz-1:0] rx_data_q;
    logic               rx_mis_q;
    logic [15:0]        tx_cnt_q, rx_cnt_q, err_cnt_q;
    logic [1:0]         err_inc;

    // Misroute and underflow are independent sources; both can land in
    // the same cycle.
    assign err_inc = {1'b0, rx_capture && in_misroute} + {1'b0, tx_underflow};

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data_q <= '0;
            rx_mis_q  <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (rx_capture) begin
                rx_data_q <= data_out;
                rx_mis_q  <= in_misroute;
                rx_cnt_q  <= sat_add(rx_cnt_q, 2'd1);
            end
            if (tx_pop) tx_cnt_q <= sat_add(tx_cnt_q, 2'd1);
            err_cnt_q <= sat_add(err_cnt_q, err_inc);
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_misroute = rx_mis_q;
    assign tx_cnt      = tx_cnt_q;
    assign rx_cnt      = rx_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mesh_terminal_port.sv
// Testbench for mesh_terminal_port: a reference model built from queues
// (TX FIFO contents, packets waiting in the mesh) and a per-packet RX phase,
// checked against every DUT output once per cycle, 1 time unit after the
// rising edge. Directed scenarios are followed by a randomized run.
module tb_mesh_terminal_port;

  localparam int W  = 40;
  localparam int D  = 16;
  localparam int PW = W - 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          tx_valid = 1'b0, tx_bcast = 1'b0, tx_mode = 1'b0;
  logic [3:0]    tx_row = '0, tx_col = '0;
  logic [PW-1:0] tx_payload = '0;
  logic          tx_ready;
  logic [W-1:0]  data_out_i_in;
  logic          pndng_i_in;
  logic          popin = 1'b0;
  logic [W-1:0]  data_out = '0;
  logic          pndng = 1'b0;
  logic          pop;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [W-1:0]  rx_data;
  logic          rx_misroute;
  logic [15:0]   tx_cnt, rx_cnt, err_cnt;

  mesh_terminal_port #(
    .pckg_sz(W), .fifo_depth(D), .MY_ROW(4'd1), .MY_COL(4'd1), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_bcast(tx_bcast),
    .tx_row(tx_row), .tx_col(tx_col), .tx_mode(tx_mode), .tx_payload(tx_payload),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
    .data_out(data_out), .pndng(pndng), .pop(pop),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_misroute(rx_misroute),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .err_cnt(err_cnt)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];   // expected TX FIFO contents, head first
  logic [W-1:0] mesh_q[$];  // packets the mesh has queued for this terminal
  int           rx_phase;   // 0 waiting, 1 pop cycle, 2 guard cycle, 3 holding
  logic [W-1:0] m_rx_data;
  logic         m_mis;
  int           m_tx_cnt, m_rx_cnt, m_err_cnt;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] mk_pkt(input bit b, input logic [3:0] r, input logic [3:0] c,
                                          input bit m, input logic [PW-1:0] p);
    return {(b ? 8'hFF : 8'h00), r, c, m, p};
  endfunction

  function automatic int sat(input int v, input int inc);
    return (v + inc > 65535) ? 65535 : v + inc;
  endfunction

  function automatic bit addressed_elsewhere(input logic [W-1:0] p);
    return (p[W-1 -: 8] != 8'hFF) && ((p[W-9 -: 4] != 4'd1) || (p[W-13 -: 4] != 4'd1));
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("tx_ready", 64'(tx_ready), 64'(exp_q.size() < D));
    check_eq("pndng_i_in", 64'(pndng_i_in), 64'(exp_q.size() > 0));
    check_eq("data_out_i_in", 64'(data_out_i_in), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'(0));
    check_eq("pop", 64'(pop), 64'(rx_phase == 1));
    check_eq("rx_valid", 64'(rx_valid), 64'(rx_phase == 3));
    check_eq("rx_data", 64'(rx_data), 64'(m_rx_data));
    check_eq("rx_misroute", 64'(rx_misroute), 64'(m_mis));
    check_eq("tx_cnt", 64'(tx_cnt), 64'(m_tx_cnt));
    check_eq("rx_cnt", 64'(rx_cnt), 64'(m_rx_cnt));
    check_eq("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
  endtask

  task automatic mesh_drive();
    pndng    = (mesh_q.size() > 0);
    data_out = (mesh_q.size() > 0) ? mesh_q[0] : '0;
  endtask

  task automatic mesh_add(input logic [W-1:0] p);
    mesh_q.push_back(p);
    mesh_drive();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    bit           do_push, do_pop, under, cap, mis;
    int           phase_n;
    logic [W-1:0] pkt;
    pkt     = mk_pkt(tx_bcast, tx_row, tx_col, tx_mode, tx_payload);
    do_push = tx_valid && (exp_q.size() < D);
    do_pop  = popin && (exp_q.size() > 0);
    under   = popin && (exp_q.size() == 0);
    cap     = (rx_phase == 1);
    mis     = addressed_elsewhere(data_out);
    phase_n = rx_phase;
    case (rx_phase)
      0: if (pndng) phase_n = 1;
      1: phase_n = 2;
      2: phase_n = 3;
      3: if (rx_ready) phase_n = 0;
      default: phase_n = 0;
    endcase
    @(posedge clk);
    #1;
    // The mesh consumes its head whenever pop was high during the cycle.
    if (cap && mesh_q.size() > 0) void'(mesh_q.pop_front());
    if (!reset) begin
      exp_q.delete();
      rx_phase  = 0;
      m_rx_data = '0;
      m_mis     = 1'b0;
      m_tx_cnt  = 0;
      m_rx_cnt  = 0;
      m_err_cnt = 0;
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(pkt);
      if (do_pop)  m_tx_cnt = sat(m_tx_cnt, 1);
      m_err_cnt = sat(m_err_cnt, int'(under) + int'(cap && mis));
      if (cap) begin
        m_rx_data = data_out;
        m_mis     = mis;
        m_rx_cnt  = sat(m_rx_cnt, 1);
      end
      rx_phase = phase_n;
    end
    mesh_drive();
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_tx(input bit v, input bit b, input logic [3:0] r, input logic [3:0] c,
                        input bit m, input logic [PW-1:0] p);
    tx_valid = v; tx_bcast = b; tx_row = r; tx_col = c; tx_mode = m; tx_payload = p;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rx_phase = 0; m_rx_data = '0; m_mis = 1'b0;
    m_tx_cnt = 0; m_rx_cnt = 0; m_err_cnt = 0;

    // Reset, then idle.
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    run(5);
    check_eq("idle_tx_ready", 64'(tx_ready), 64'(1));
    check_eq("idle_tx_cnt", 64'(tx_cnt), 64'(0));

    // Single formatted packet, then consumed by the mesh.
    set_tx(1, 0, 4'h2, 4'h3, 1, 23'h1ABCDE);
    cycle();
    set_tx(0, 0, 0, 0, 0, '0);
    check_eq("fmt_pkt", 64'(data_out_i_in), 64'({8'h00, 4'h2, 4'h3, 1'b1, 23'h1ABCDE}));
    check_eq("fmt_pndng", 64'(pndng_i_in), 64'(1));
    popin = 1'b1;
    cycle();
    popin = 1'b0;
    check_eq("single_tx_cnt", 64'(tx_cnt), 64'(1));
    check_eq("single_empty", 64'(pndng_i_in), 64'(0));

    // Fill to full, try a 17th, pop all; twice to cross the pointer wrap.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < D + 1; k++) begin
        set_tx(1, k[0], 4'(k), 4'(rep), k[1], PW'(32'h1000 * rep + k));
        cycle();
      end
      check_eq("full_tx_ready", 64'(tx_ready), 64'(0));
      // Pop while tx_valid stays high: the push stays blocked this cycle.
      popin = 1'b1;
      cycle();
      set_tx(0, 0, 0, 0, 0, '0);
      run(D - 1);
      popin = 1'b0;
      cycle();
    end
    check_eq("fill_tx_cnt", 64'(tx_cnt), 64'(1 + 2 * D));

    // RX hold: one pop only while rx_valid stays high.
    rx_ready = 1'b0;
    mesh_add(mk_pkt(0, 4'd1, 4'd1, 0, 23'h00AA55));
    mesh_add(mk_pkt(0, 4'd1, 4'd1, 1, 23'h0055AA));
    run(25);
    check_eq("hold_rx_cnt", 64'(rx_cnt), 64'(1));
    check_eq("hold_rx_valid", 64'(rx_valid), 64'(1));
    rx_ready = 1'b1;
    run(6);
    check_eq("second_rx_cnt", 64'(rx_cnt), 64'(2));

    // Misroute, then the same destination as broadcast.
    mesh_add(mk_pkt(0, 4'd3, 4'd0, 0, 23'h012345));
    run(6);
    check_eq("mis_err", 64'(err_cnt), 64'(1));
    mesh_add(mk_pkt(1, 4'd3, 4'd0, 0, 23'h012345));
    run(6);
    check_eq("bcast_err", 64'(err_cnt), 64'(1));
    check_eq("bcast_mis", 64'(rx_misroute), 64'(0));

    // Underflow pop, then a packet still comes out intact.
    popin = 1'b1;
    cycle();
    popin = 1'b0;
    check_eq("underflow_err", 64'(err_cnt), 64'(2));
    set_tx(1, 0, 4'h5, 4'h6, 0, 23'h777777);
    cycle();
    set_tx(0, 0, 0, 0, 0, '0);
    popin = 1'b1;
    cycle();
    popin = 1'b0;

    // Reset while holding a packet with 3 TX entries queued.
    rx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_tx(1, 0, 4'(k), 4'(k), 0, PW'(k + 100));
      cycle();
    end
    set_tx(0, 0, 0, 0, 0, '0);
    mesh_add(mk_pkt(0, 4'd1, 4'd1, 0, 23'h3C3C3C));
    for (int k = 0; k < 20 && rx_phase != 3; k++) cycle();
    check_eq("reached_hold", 64'(rx_valid), 64'(1));
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check_eq("rst_pndng", 64'(pndng_i_in), 64'(0));
    check_eq("rst_rx_valid", 64'(rx_valid), 64'(0));
    check_eq("rst_err", 64'(err_cnt), 64'(0));
    rx_ready = 1'b1;
    run(4);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      set_tx($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
             4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), PW'($urandom));
      popin    = ($urandom_range(0, 2) == 0);
      rx_ready = ($urandom_range(0, 1) == 1);
      if (mesh_q.size() < 4 && $urandom_range(0, 3) == 0)
        mesh_add(mk_pkt($urandom_range(0, 3) == 0, 4'($urandom_range(0, 2)),
                        4'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), PW'($urandom)));
      reset = ($urandom_range(0, 499) != 0);
      cycle();
    end
    reset = 1'b1;
    set_tx(0, 0, 0, 0, 0, '0);
    popin = 1'b0;
    rx_ready = 1'b1;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
